// File: rtl/divider.sv
// Sequential 8-bit signed restoring divider: one quotient bit per clock on
// operand magnitudes, then a single sign-fix cycle that writes the results.
module divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dvd,
  input  logic [7:0] dvs,
  output logic [7:0] quot,
  output logic [7:0] rem,
  output logic       busy,
  output logic       done,
  output logic       dbz,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] q, dsor, dvd_l, r;
  logic [3:0] cnt;
  logic       sign_d, sign_q, zero_l, ovf_l;
  logic [8:0] r_sh, t;

  // Shifted remainder never exceeds 255, so a 9-bit trial subtract's MSB is the borrow
  assign r_sh = {r, q[7]};
  assign t    = r_sh - {1'b0, dsor};

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = (dvs == 8'h00) ? FIX : CALC;
    else begin
      case (state)
        CALC:    if (cnt == 4'd7) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      dsor   <= '0;
      dvd_l  <= '0;
      r      <= '0;
      cnt    <= '0;
      sign_d <= 1'b0;
      sign_q <= 1'b0;
      zero_l <= 1'b0;
      ovf_l  <= 1'b0;
      quot   <= '0;
      rem    <= '0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else if (start) begin
      q      <= dvd[7] ? -dvd : dvd;
      dsor   <= dvs[7] ? -dvs : dvs;
      dvd_l  <= dvd;
      r      <= '0;
      cnt    <= '0;
      sign_d <= dvd[7];
      sign_q <= dvd[7] ^ dvs[7];
      zero_l <= (dvs == 8'h00);
      ovf_l  <= (dvd == 8'h80) && (dvs == 8'hFF);
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          q   <= {q[6:0], ~t[8]};
          r   <= t[8] ? r_sh[7:0] : t[7:0];
          cnt <= cnt + 4'd1;
        end
        FIX: begin
          if (zero_l) begin
            quot <= 8'hFF;
            rem  <= dvd_l;
            dbz  <= 1'b1;
          end else begin
            quot <= sign_q ? -q : q;
            rem  <= sign_d ? -r : r;
            ovf  <= ovf_l;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Bench for divider: a timeline model with C-style truncating arithmetic,
// checked every cycle, plus directed vectors with hand-computed results.
module tb_divider;

  logic       clk, rst_n, start;
  logic [7:0] dvd, dvs, quot, rem;
  logic       busy, done, dbz, ovf;

  int checks = 0;
  int errs   = 0;
  bit chk_en = 0;

  divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dvd(dvd), .dvs(dvs),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h required %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z, output logic o);
    int sa, sb, qq, rr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    z = 0; o = 0;
    if (sb == 0) begin
      q = 8'hFF; r = a; z = 1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[7:0];
      r  = rr[7:0];
      o  = (sa == -128) && (sb == -1);
    end
  endfunction

  // Model: results appear a fixed number of cycles after the last start
  logic [7:0] m_q, m_r, lat_a, lat_b;
  logic       m_busy, m_done, m_dbz, m_ovf;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] tq, tr;
    logic       tz, to;
    if (!rst_n) begin
      m_q <= 0; m_r <= 0; m_busy <= 0; m_done <= 0; m_dbz <= 0; m_ovf <= 0;
      m_cnt <= 0; lat_a <= 0; lat_b <= 0;
    end else if (start) begin
      lat_a <= dvd; lat_b <= dvs;
      m_cnt <= (dvs == 0) ? 1 : 9;
      m_busy <= 1; m_done <= 0; m_dbz <= 0; m_ovf <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        ref_div(lat_a, lat_b, tq, tr, tz, to);
        m_q <= tq; m_r <= tr; m_dbz <= tz; m_ovf <= to;
        m_busy <= 0; m_done <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("busy", {7'b0, busy}, {7'b0, m_busy});
      chk("done", {7'b0, done}, {7'b0, m_done});
      chk("quot", quot, m_q);
      chk("rem",  rem,  m_r);
      chk("dbz",  {7'b0, dbz}, {7'b0, m_dbz});
      chk("ovf",  {7'b0, ovf}, {7'b0, m_ovf});
      if (busy && done) chk("busy_and_done", 8'd1, 8'd0);
    end
  end

  // Pulse start for one cycle, then wait for done, counting busy cycles
  task automatic go(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                    output int nbusy);
    @(negedge clk);
    dvd = a; dvs = b; start = 1;
    @(negedge clk);
    start = 0;
    nbusy = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nbusy++;
      @(negedge clk);
      if (scramble) begin dvd = 8'($urandom); dvs = 8'($urandom); end
    end
    if (!done) chk("done_timeout", {7'b0, done}, 8'd1);
  endtask

  initial begin
    int nb;
    logic [7:0] tq, tr, a, b;
    logic tz, to;

    rst_n = 0; start = 0; dvd = 0; dvs = 0;
    // pin the model against hand-computed values
    ref_div(8'd100, 8'd7, tq, tr, tz, to);
    chk("model_100_7_q", tq, 8'h0E); chk("model_100_7_r", tr, 8'h02);
    ref_div(8'h9C, 8'd7, tq, tr, tz, to);
    chk("model_m100_7_q", tq, 8'hF2); chk("model_m100_7_r", tr, 8'hFE);
    ref_div(8'h80, 8'hFF, tq, tr, tz, to);
    chk("model_ovf_q", tq, 8'h80); chk("model_ovf_flag", {7'b0, to}, 8'd1);

    repeat (3) @(negedge clk);
    chk("rst_quot", quot, 8'h00); chk("rst_rem", rem, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'd0); chk("rst_done", {7'b0, done}, 8'd0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);

    go(8'd100, 8'd7, 0, nb);
    chk("lat_busy_cycles", nb[7:0], 8'd9);
    chk("t1_quot", quot, 8'h0E); chk("t1_rem", rem, 8'h02);

    go(8'h9C, 8'd7, 0, nb);
    chk("t2_quot", quot, 8'hF2); chk("t2_rem", rem, 8'hFE);
    go(8'd100, 8'hF9, 0, nb);
    chk("t3_quot", quot, 8'hF2); chk("t3_rem", rem, 8'h02);

    go(8'd5, 8'd0, 0, nb);
    chk("dbz_busy_cycles", nb[7:0], 8'd1);
    chk("dbz_flag", {7'b0, dbz}, 8'd1);
    chk("dbz_quot", quot, 8'hFF); chk("dbz_rem", rem, 8'h05);

    go(8'h80, 8'hFF, 0, nb);
    chk("ovf_quot", quot, 8'h80); chk("ovf_rem", rem, 8'h00);
    chk("ovf_flag", {7'b0, ovf}, 8'd1); chk("ovf_dbz", {7'b0, dbz}, 8'd0);
    go(8'd6, 8'd3, 0, nb);
    chk("ovf_clr", {7'b0, ovf}, 8'd0);
    chk("t6_quot", quot, 8'h02); chk("t6_rem", rem, 8'h00);

    // restart four cycles into a division
    @(negedge clk);
    dvd = 8'd50; dvs = 8'd3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    go(8'd9, 8'd4, 0, nb);
    chk("restart_busy_cycles", nb[7:0], 8'd9);
    chk("restart_quot", quot, 8'h02); chk("restart_rem", rem, 8'h01);

    // reset mid-division
    @(negedge clk);
    dvd = 8'd50; dvs = 8'd3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_quot", quot, 8'h00); chk("mid_rst_rem", rem, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'd0); chk("mid_rst_done", {7'b0, done}, 8'd0);
    chk("mid_rst_flags", {6'b0, dbz, ovf}, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", {7'b0, done}, 8'd0);

    // random sweep with operand scrambling during CALC
    for (int i = 0; i < 1000; i++) begin
      do begin
        a = 8'($urandom); b = 8'($urandom);
      end while (b == 0 || (a == 8'h80 && b == 8'hFF));
      go(a, b, 1, nb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
